// File: rtl/pwm_regbank_if.sv
// SPI-side byte bus seen by the PWM register bank: address, write data, write strobe, readback.
// b_write_i is a level strobe from another clock domain with no ready; address and data are held stable while it is high.
interface pwm_regbank_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_data_i;
  logic          b_write_i;
  logic [DW-1:0] b_data_o;

  modport master (
    output b_addr_i,
    output b_data_i,
    output b_write_i,
    input  b_data_o
  );

  modport slave (
    input  b_addr_i,
    input  b_data_i,
    input  b_write_i,
    output b_data_o
  );
endinterface

// File: rtl/pwm_regbank.sv
// Register bank between the SPI byte bus and the PWM channels: synchronised writes,
// shadow/active duty registers, and a prescaler tick that replaces a divided clock.
module pwm_regbank #(
  parameter int N_CH  = 3,
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DIV_W = 21
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  pwm_regbank_if.slave       bus,
  output logic [N_CH*DW-1:0] duty_o,
  output logic               tick_o,
  output logic               period_end_o
);

  localparam int SW = $clog2(DIV_W);
  localparam logic [SW-1:0] DIV_MAX = SW'(DIV_W - 1);

  logic              sync1, sync2, sync3;
  logic              vld1, vld2, armed;
  logic              wr_pulse, wr_commit, commit;
  logic [SW-1:0]     div_sel;
  logic              auto_q;
  logic [DW-1:0]     shadow [N_CH];
  logic [DW-1:0]     active [N_CH];
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  tick_mask;
  logic [DW-1:0]     pcnt;
  logic [DW-1:0]     rd_data;

  // Edge detection is armed only once the synchroniser has reported the strobe low
  // after reset, so a strobe still high across reset release never writes.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      vld1  <= 1'b0;
      vld2  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= bus.b_write_i;
      sync2 <= sync1;
      sync3 <= sync2;
      vld1  <= 1'b1;
      vld2  <= vld1;
      armed <= armed | (vld2 & ~sync2);
    end
  end

  assign wr_pulse  = sync2 & ~sync3 & armed;
  assign wr_commit = wr_pulse && (bus.b_addr_i == AW'(N_CH + 1)) && bus.b_data_i[0];
  assign commit    = wr_commit | (period_end_o & auto_q);

  assign tick_mask    = {DIV_W{1'b1}} >> (DIV_MAX - div_sel);
  assign tick_o       = (cnt & tick_mask) == tick_mask;
  assign period_end_o = tick_o && (pcnt == {DW{1'b1}});

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt  <= '0;
      pcnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (tick_o) pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      div_sel <= SW'(3);
      auto_q  <= 1'b0;
    end else if (wr_pulse) begin
      if (bus.b_addr_i == '0)
        div_sel <= (bus.b_data_i > DW'(DIV_W - 1)) ? DIV_MAX : bus.b_data_i[SW-1:0];
      if (bus.b_addr_i == AW'(N_CH + 1))
        auto_q <= bus.b_data_i[1];
    end
  end

  // Commit reads the pre-edge shadow, so a shadow write landing on the same edge waits.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int k = 0; k < N_CH; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_pulse && (bus.b_addr_i == AW'(k + 1))) shadow[k] <= bus.b_data_i;
        if (commit) active[k] <= shadow[k];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_duty
    assign duty_o[g*DW +: DW] = active[g];
  end

  always_comb begin
    rd_data = '0;
    if (bus.b_addr_i == '0) begin
      rd_data = DW'(div_sel);
    end else if (bus.b_addr_i == AW'(N_CH + 1)) begin
      rd_data = DW'({auto_q, 1'b0});
    end else begin
      for (int k = 0; k < N_CH; k++)
        if (bus.b_addr_i == AW'(k + 1)) rd_data = shadow[k];
    end
  end

  assign bus.b_data_o = rd_data;

endmodule

// File: tb/tb_pwm_regbank.sv
// Directed and randomised bench for pwm_regbank against a cycle-count reference model.
module tb_pwm_regbank;
  localparam int N_CH  = 3;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DIV_W = 21;

  logic               clk_i = 1'b0;
  logic               nrst_i;
  logic [N_CH*DW-1:0] duty_o;
  logic               tick_o;
  logic               period_end_o;

  always #5 clk_i = ~clk_i;

  pwm_regbank_if #(.AW(AW), .DW(DW)) bus ();

  pwm_regbank #(.N_CH(N_CH), .DW(DW), .AW(AW), .DIV_W(DIV_W)) dut (
    .clk_i        (clk_i),
    .nrst_i       (nrst_i),
    .bus          (bus.slave),
    .duty_o       (duty_o),
    .tick_o       (tick_o),
    .period_end_o (period_end_o)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model state
  int unsigned cyc;
  int unsigned ds;
  int unsigned pcnt_m;
  bit          auto_m;
  logic [7:0]  sh_m  [N_CH];
  logic [7:0]  act_m [N_CH];
  int          wr_cd;
  logic [7:0]  wr_addr_m, wr_data_m;

  function automatic bit m_tick_at(int unsigned c);
    int unsigned period;
    period = 1 << (ds + 1);
    return ((c % (1 << DIV_W)) % period) == period - 1;
  endfunction

  function automatic logic [31:0] m_duty();
    return {8'h00, act_m[2], act_m[1], act_m[0]};
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (a == 0) return 32'(ds);
    if (a >= 1 && a <= N_CH) return 32'(sh_m[a-1]);
    if (a == N_CH + 1) return auto_m ? 32'd2 : 32'd0;
    return 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; ds = 3; pcnt_m = 0; auto_m = 1'b0; wr_cd = 0;
    for (int k = 0; k < N_CH; k++) begin
      sh_m[k] = '0;
      act_m[k] = '0;
    end
  endtask

  task automatic step();
    bit t, pe, do_wr, cmt;
    t     = m_tick_at(cyc);
    pe    = t && (pcnt_m == 255);
    do_wr = (wr_cd == 1);
    @(posedge clk_i);
    #1;
    if (wr_cd > 0) wr_cd--;
    cmt = pe && auto_m;
    if (do_wr && wr_addr_m == 8'(N_CH + 1) && wr_data_m[0]) cmt = 1'b1;
    if (cmt) for (int k = 0; k < N_CH; k++) act_m[k] = sh_m[k];
    if (do_wr) begin
      if (wr_addr_m == 0) ds = (wr_data_m > DIV_W - 1) ? DIV_W - 1 : int'(wr_data_m);
      else if (wr_addr_m <= N_CH) sh_m[wr_addr_m-1] = wr_data_m;
      else if (wr_addr_m == 8'(N_CH + 1)) auto_m = wr_data_m[1];
    end
    if (t) pcnt_m = (pcnt_m + 1) % 256;
    cyc++;
    check("tick", 32'(tick_o), 32'(m_tick_at(cyc)));
    check("period_end", 32'(period_end_o), 32'(m_tick_at(cyc) && pcnt_m == 255));
    check("duty", 32'(duty_o), m_duty());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_check(input string tag, input int a);
    bus.b_addr_i = 8'(a);
    #1;
    check(tag, 32'(bus.b_data_o), m_read(a));
  endtask

  task automatic spi_write(input int a, input int d, input int hold);
    bus.b_addr_i  = 8'(a);
    bus.b_data_i  = 8'(d);
    bus.b_write_i = 1'b1;
    wr_addr_m = 8'(a);
    wr_data_m = 8'(d);
    wr_cd = 3;
    steps(hold);
    bus.b_write_i = 1'b0;
    steps(3);
  endtask

  // Step until a write raised now would land in a period_end cycle.
  task automatic align_to_boundary();
    int n = 0;
    while (!(m_tick_at(cyc + 2) &&
             ((pcnt_m + m_tick_at(cyc) + m_tick_at(cyc + 1)) % 256 == 255)) && n < 3000) begin
      step();
      n++;
    end
    check("align_bound", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    int a, d, n;
    nrst_i = 1'b0;
    bus.b_addr_i = '0;
    bus.b_data_i = '0;
    bus.b_write_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("rst_duty", 32'(duty_o), 32'd0);
    check("rst_tick", 32'(tick_o), 32'd0);
    check("rst_pe", 32'(period_end_o), 32'd0);
    read_check("rst_div", 0);
    for (int k = 1; k <= N_CH + 1; k++) read_check("rst_reg", k);
    read_check("rst_unmapped", 7);
    nrst_i = 1'b1;

    // Free run: tick every 16 cycles, period_end every 4096.
    steps(4100);

    spi_write(1, 8'h80, 4);
    read_check("shadow1", 1);
    check("no_commit", 32'(duty_o[7:0]), 32'd0);

    spi_write(4, 8'h01, 4);
    check("commit_duty0", 32'(duty_o[7:0]), 32'h80);
    read_check("ctrl_commit_reads0", 4);

    spi_write(4, 8'h02, 4);
    spi_write(2, 8'h40, 4);
    read_check("ctrl_auto", 4);
    n = 0;
    while (!period_end_o && n < 5000) begin
      step();
      n++;
    end
    check("pe_seen", 32'(period_end_o), 32'd1);
    check("duty1_before", 32'(duty_o[15:8]), 32'd0);
    step();
    check("duty1_auto", 32'(duty_o[15:8]), 32'h40);

    // Fast prescaler for boundary collisions.
    spi_write(0, 0, 4);
    align_to_boundary();
    spi_write(1, 8'hA5, 4);
    check("old_shadow_committed", 32'(duty_o[7:0]), 32'h80);
    align_to_boundary();
    spi_write(3, 8'h3C, 4);
    align_to_boundary();
    spi_write(4, 8'h03, 4);
    check("dual_commit", 32'(duty_o), 32'h3C40A5);
    align_to_boundary();
    spi_write(2, 8'h17, 4);
    align_to_boundary();
    spi_write(4, 8'h00, 4);
    read_check("auto_off", 4);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 7);
      d = $urandom_range(0, 255);
      if (a == 0) d = d & 3;
      spi_write(a, d, $urandom_range(3, 6));
      read_check("rand_read", $urandom_range(0, 7));
      steps($urandom_range(0, 20));
    end

    spi_write(0, 8'hFF, 4);
    read_check("div_clamp", 0);
    steps(200);
    spi_write(7, 8'h3C, 4);
    read_check("unmapped7", 7);
    for (int k = 1; k <= N_CH + 1; k++) read_check("after_unmapped", k);

    // Held strobe: address changes after the capture window must not write.
    bus.b_addr_i  = 8'd2;
    bus.b_data_i  = 8'h99;
    bus.b_write_i = 1'b1;
    wr_addr_m = 8'd2;
    wr_data_m = 8'h99;
    wr_cd = 3;
    steps(5);
    bus.b_addr_i = 8'd3;
    bus.b_data_i = 8'h11;
    steps(45);
    bus.b_write_i = 1'b0;
    steps(3);
    read_check("hold_once_a2", 2);
    read_check("hold_once_a3", 3);

    // Reset during a strobe, with the strobe still high after release.
    bus.b_addr_i  = 8'd1;
    bus.b_data_i  = 8'h55;
    bus.b_write_i = 1'b1;
    step();
    nrst_i = 1'b0;
    #1;
    check("midrst_duty", 32'(duty_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    nrst_i = 1'b1;
    model_reset();
    steps(12);
    read_check("midrst_no_write", 1);
    read_check("midrst_div", 0);
    bus.b_write_i = 1'b0;
    steps(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
